// File: rtl/sachen_prot_core.sv
// Shared register/protection core for Sachen mappers: 8259-style index/data file
// (mode 0) and JV001-style accumulator with inc/invert/output latch (mode 1).
module sachen_prot_core #(
    parameter int              NUM_REGS = 8,
    parameter int              REG_W    = 3,
    parameter int              ACC_W    = 6,
    parameter int              INC_W    = 4,
    parameter logic [ACC_W-1:0] INV_MASK = 6'h30,
    parameter logic [7:0]      RD_FILL  = 8'h38,
    localparam int             IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ce,
    input  logic                      enable,
    input  logic                      mode,
    input  logic [15:0]               prg_ain,
    input  logic                      prg_write,
    input  logic [7:0]                prg_din,
    input  logic [7:0]                open_bus,
    output logic                      rd_hit,
    output logic [7:0]                rd_data,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic [IDX_W-1:0]          idx,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      mirror
);

    logic [REG_W-1:0] regs_q [NUM_REGS];
    logic [REG_W-1:0] regs_d [NUM_REGS];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] in_q, in_d;
    logic [ACC_W-1:0] out_q, out_d;
    logic             inc_q, inc_d;
    logic             inv_q, inv_d;
    logic             mirror_q, mirror_d;

    logic             win0, win1, wr_en;
    logic [ACC_W-1:0] acc_view;
    logic [7:0]       rd_m0, rd_m1;
    logic             unused_bits;

    assign win0  = (prg_ain[15:14] == 2'b01) & prg_ain[8];
    assign win1  = (prg_ain[15:13] == 3'b010) & prg_ain[8];
    assign wr_en = ce & enable & prg_write;

    assign acc_view    = acc_q ^ (inv_q ? INV_MASK : '0);
    assign unused_bits = ^{prg_ain[12:9], prg_ain[7:2], prg_din};

    always_comb begin
        regs_d   = regs_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        in_d     = in_q;
        out_d    = out_q;
        inc_d    = inc_q;
        inv_d    = inv_q;
        mirror_d = mirror_q;
        if (wr_en) begin
            if (!mode) begin
                if (win0) begin
                    if (!prg_ain[0]) begin
                        idx_d = prg_din[IDX_W-1:0];
                    end else begin
                        regs_d[idx_q] = prg_din[REG_W-1:0];
                    end
                end
            end else begin
                if (win1) begin
                    case (prg_ain[1:0])
                        2'd0: begin
                            if (inc_q) begin
                                // Only the low INC_W bits count; upper bits hold.
                                acc_d[INC_W-1:0] = acc_q[INC_W-1:0] + INC_W'(1);
                            end else begin
                                acc_d = in_q ^ (inv_q ? INV_MASK : '0);
                            end
                        end
                        2'd1:    inv_d = prg_din[0];
                        2'd2:    in_d  = prg_din[ACC_W-1:0];
                        default: inc_d = prg_din[0];
                    endcase
                end
                if (prg_ain[15]) begin
                    out_d    = acc_q;
                    mirror_d = inv_q;
                end
            end
        end
    end

    always_comb begin
        rd_m0              = RD_FILL;
        rd_m0[IDX_W-1:0]   = ~idx_q;
        rd_m1              = open_bus;
        rd_m1[ACC_W-1:0]   = acc_view;
        rd_hit             = enable & (mode ? win1 : win0);
        rd_data            = open_bus;
        if (rd_hit) begin
            if (mode) begin
                rd_data = rd_m1;
            end else if (prg_ain[0]) begin
                rd_data = rd_m0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q   <= '{default: '0};
            idx_q    <= '0;
            acc_q    <= '0;
            in_q     <= '0;
            out_q    <= '0;
            inc_q    <= 1'b0;
            inv_q    <= 1'b0;
            mirror_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            in_q     <= in_d;
            out_q    <= out_d;
            inc_q    <= inc_d;
            inv_q    <= inv_d;
            mirror_q <= mirror_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_flat[k*REG_W +: REG_W] = regs_q[k];
        end
    end

    assign idx     = idx_q;
    assign acc_out = out_q;
    assign mirror  = mirror_q;

endmodule

// File: tb/tb_sachen_prot_core.sv
// Directed vector table plus hand sequences for wrap, mode switch and reset cases
// of sachen_prot_core with default parameters.
module tb_sachen_prot_core;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce, enable, mode, prg_write;
    logic [15:0] prg_ain;
    logic [7:0]  prg_din, open_bus;
    logic        rd_hit;
    logic [7:0]  rd_data;
    logic [23:0] regs_flat;
    logic [2:0]  idx;
    logic [5:0]  acc_out;
    logic        mirror;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    sachen_prot_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .enable    (enable),
        .mode      (mode),
        .prg_ain   (prg_ain),
        .prg_write (prg_write),
        .prg_din   (prg_din),
        .open_bus  (open_bus),
        .rd_hit    (rd_hit),
        .rd_data   (rd_data),
        .regs_flat (regs_flat),
        .idx       (idx),
        .acc_out   (acc_out),
        .mirror    (mirror)
    );

    typedef struct {
        logic        m, c, e, w;
        logic [15:0] a;
        logic [7:0]  d, ob;
        logic        hit, chk_rd;
        logic [7:0]  rd;
        logic [2:0]  idx;
        logic [5:0]  ao;
        logic        mi;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic m, c, e, w, input logic [15:0] a, input logic [7:0] d, ob,
                       input logic hit, chk_rd, input logic [7:0] rd, input logic [2:0] ix,
                       input logic [5:0] ao, input logic mi);
        vec_t v;
        v.m = m; v.c = c; v.e = e; v.w = w; v.a = a; v.d = d; v.ob = ob;
        v.hit = hit; v.chk_rd = chk_rd; v.rd = rd; v.idx = ix; v.ao = ao; v.mi = mi;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic m, c, e, w, input logic [15:0] a, input logic [7:0] d, ob);
        @(negedge clk);
        mode = m; ce = c; enable = e; prg_write = w;
        prg_ain = a; prg_din = d; open_bus = ob;
        #1;
    endtask

    task automatic do_wr(input logic m, input logic [15:0] a, input logic [7:0] d);
        drive(m, 1'b1, 1'b1, 1'b1, a, d, 8'hA5);
        @(posedge clk);
        #1;
    endtask

    task automatic do_rd(input logic m, input logic [15:0] a, output logic [7:0] rd);
        drive(m, 1'b1, 1'b1, 1'b0, a, 8'h00, 8'h00);
        rd = rd_data;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp_rd;
        vec_t v;

        reset_n = 1'b0; ce = 1'b0; enable = 1'b0; mode = 1'b0; prg_write = 1'b0;
        prg_ain = '0; prg_din = '0; open_bus = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // mode 0: index/data file, gating, out-of-window addresses
        add(0,1,1,0,16'h4101,8'h00,8'hA5, 1,1,8'h3F, 3'd0,6'h00,0);
        add(0,1,1,1,16'h4100,8'h05,8'hA5, 1,0,8'h00, 3'd5,6'h00,0);
        add(0,1,1,1,16'h4101,8'h03,8'hA5, 1,1,8'h3A, 3'd5,6'h00,0);
        add(0,1,1,1,16'h4100,8'hFD,8'hA5, 1,0,8'h00, 3'd5,6'h00,0);
        add(0,1,1,0,16'h4101,8'h00,8'hA5, 1,1,8'h3A, 3'd5,6'h00,0);
        add(0,0,1,1,16'h4100,8'h02,8'hA5, 1,0,8'h00, 3'd5,6'h00,0);
        add(0,1,0,1,16'h4100,8'h02,8'hA5, 0,1,8'hA5, 3'd5,6'h00,0);
        add(0,1,1,1,16'h8000,8'h07,8'hA5, 0,1,8'hA5, 3'd5,6'h00,0);
        add(0,1,1,0,16'h4000,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h00,0);
        add(0,1,1,0,16'hC101,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h00,0);
        // mode 1: load with invert, output latch, gating
        add(1,1,1,1,16'h4102,8'h2A,8'hA5, 1,1,8'h80, 3'd5,6'h00,0);
        add(1,1,1,1,16'h4101,8'h01,8'hA5, 1,1,8'h80, 3'd5,6'h00,0);
        add(1,1,1,1,16'h4100,8'h77,8'hA5, 1,1,8'hB0, 3'd5,6'h00,0);
        add(1,1,1,0,16'h4100,8'h00,8'hA5, 1,1,8'hAA, 3'd5,6'h00,0);
        add(1,1,1,1,16'h8000,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h5103,8'h00,8'h00, 1,1,8'h2A, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h6100,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h4000,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h1A,1);
        add(1,0,1,1,16'h4102,8'h3F,8'hA5, 1,1,8'hAA, 3'd5,6'h1A,1);
        add(1,1,0,1,16'h4101,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h1A,1);
        add(1,1,0,1,16'h8000,8'h00,8'hA5, 0,1,8'hA5, 3'd5,6'h1A,1);
        add(1,1,1,1,16'h4100,8'h00,8'hA5, 1,1,8'hAA, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h4100,8'h00,8'h00, 1,1,8'h2A, 3'd5,6'h1A,1);
        // mode 1: plain load, then increment across the INC_W boundary
        add(1,1,1,1,16'h4101,8'h00,8'hA5, 1,1,8'hAA, 3'd5,6'h1A,1);
        add(1,1,1,1,16'h4102,8'h2F,8'hA5, 1,1,8'h9A, 3'd5,6'h1A,1);
        add(1,1,1,1,16'h4100,8'h00,8'hA5, 1,1,8'h9A, 3'd5,6'h1A,1);
        add(1,1,1,1,16'h4103,8'h01,8'hA5, 1,1,8'hAF, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h4100,8'h00,8'h00, 1,1,8'h2F, 3'd5,6'h1A,1);
        add(1,1,1,1,16'h4100,8'h00,8'hA5, 1,1,8'hAF, 3'd5,6'h1A,1);
        add(1,1,1,0,16'h4100,8'h00,8'h00, 1,1,8'h20, 3'd5,6'h1A,1);

        foreach (vq[i]) begin
            v = vq[i];
            drive(v.m, v.c, v.e, v.w, v.a, v.d, v.ob);
            chk($sformatf("v%0d_rd_hit", i), 32'(rd_hit), 32'(v.hit));
            if (v.chk_rd) chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(v.rd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idx", i), 32'(idx), 32'(v.idx));
            chk($sformatf("v%0d_acc_out", i), 32'(acc_out), 32'(v.ao));
            chk($sformatf("v%0d_mirror", i), 32'(mirror), 32'(v.mi));
        end
        chk("regs_after_vectors", 32'(regs_flat), 32'h018000);

        // 16 increments from 0x20: low nibble walks and wraps, upper bits hold
        for (int i = 0; i < 16; i++) begin
            do_wr(1'b1, 16'h4100, 8'h00);
            do_rd(1'b1, 16'h4100, rd);
            exp_rd = 8'h20 | 8'((i + 1) & 15);
            chk($sformatf("wrap_step%0d", i), 32'(rd), 32'(exp_rd));
        end
        do_wr(1'b1, 16'h8000, 8'h00);
        chk("wrap_acc_out", 32'(acc_out), 32'h20);
        chk("wrap_mirror", 32'(mirror), 32'h0);

        // mode switch keeps state; $8000 ignored in mode 0
        do_wr(1'b1, 16'h4103, 8'h00);
        do_wr(1'b1, 16'h4102, 8'h0A);
        do_wr(1'b1, 16'h4100, 8'h00);
        do_wr(1'b1, 16'h8000, 8'h00);
        do_wr(1'b1, 16'h4102, 8'h15);
        do_wr(1'b1, 16'h4100, 8'h00);
        chk("sw_acc_out_pre", 32'(acc_out), 32'h0A);
        do_wr(1'b0, 16'h8000, 8'h00);
        chk("sw_acc_out_m0", 32'(acc_out), 32'h0A);
        do_wr(1'b0, 16'h4100, 8'h01);
        chk("sw_idx_m0", 32'(idx), 32'h1);
        do_wr(1'b0, 16'h4101, 8'hFF);
        chk("sw_regs_m0", 32'(regs_flat), 32'h018038);
        do_rd(1'b1, 16'h4100, rd);
        chk("sw_acc_back_m1", 32'(rd), 32'h15);
        chk("sw_idx_m1", 32'(idx), 32'h1);

        // asynchronous reset pulse between clock edges
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h4101, 8'h00, 8'hA5);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_idx", 32'(idx), 32'h0);
        chk("rst_regs", 32'(regs_flat), 32'h0);
        chk("rst_acc_out", 32'(acc_out), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h3F);
        #2 reset_n = 1'b1;

        // reset held across a qualifying write: the write is lost
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h4100, 8'h03, 8'hA5);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstwr_idx", 32'(idx), 32'h0);
        @(negedge clk);
        prg_write = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwr_idx_after", 32'(idx), 32'h0);
        do_rd(1'b1, 16'h4100, rd);
        chk("rst_acc_m1", 32'(rd), 32'h00);
        do_wr(1'b0, 16'h4100, 8'h06);
        chk("post_rst_idx", 32'(idx), 32'h6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
